// File: rtl/conv_tile_scheduler.sv
// rtl/conv_tile_scheduler.sv - multi-tile load/compute/store sequencer for the tiled conv datapath
module conv_tile_scheduler #(
  parameter int N         = 16,
  parameter int M         = 16,
  parameter int R         = 32,
  parameter int C         = 16,
  parameter int Tn        = 8,
  parameter int Tm        = 8,
  parameter int Tr        = 16,
  parameter int Tc        = 8,
  parameter int IW        = 8,
  parameter int STORE_GAP = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          conv_start,
  output logic          conv_done,
  output logic          busy,
  output logic          in_fm_load_start,
  input  logic          in_fm_load_done,
  output logic          weight_load_start,
  input  logic          weight_load_done,
  output logic          out_fm_load_start,
  input  logic          out_fm_load_done,
  output logic          compute_start,
  input  logic          compute_done,
  output logic          store_start,
  input  logic          store_done,
  output logic [IW-1:0] tile_n_idx,
  output logic [IW-1:0] tile_m_idx,
  output logic [IW-1:0] tile_r_idx,
  output logic [IW-1:0] tile_c_idx,
  output logic [IW-1:0] tile_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMP, S_GAP, S_STORE, S_NEXT} state_t;

  localparam int NT = N / Tn;
  localparam int MT = M / Tm;
  localparam int RT = R / Tr;
  localparam int CT = C / Tc;
  localparam int GW = (STORE_GAP > 0) ? $clog2(STORE_GAP + 1) : 1;

  state_t        state_q, state_d;
  logic          ld_start_q, ld_start_d;
  logic          comp_start_q, comp_start_d;
  logic          st_start_q, st_start_d;
  logic          f_in_q, f_in_d, f_wt_q, f_wt_d, f_of_q, f_of_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [IW-1:0] n_q, n_d, m_q, m_d, r_q, r_d, c_q, c_d, cnt_q, cnt_d;
  logic          m_last, c_last, r_last, n_last, tile_last;
  logic          all_in, all_wt, all_of;

  assign m_last    = (m_q == IW'(MT - 1));
  assign c_last    = (c_q == IW'(CT - 1));
  assign r_last    = (r_q == IW'(RT - 1));
  assign n_last    = (n_q == IW'(NT - 1));
  assign tile_last = m_last && c_last && r_last && n_last;

  always_comb begin
    state_d      = state_q;
    ld_start_d   = 1'b0;
    comp_start_d = 1'b0;
    st_start_d   = 1'b0;
    f_in_d       = f_in_q;
    f_wt_d       = f_wt_q;
    f_of_d       = f_of_q;
    gap_d        = gap_q;
    n_d          = n_q;
    m_d          = m_q;
    r_d          = r_q;
    c_d          = c_q;
    cnt_d        = cnt_q;
    all_in       = f_in_q | in_fm_load_done;
    all_wt       = f_wt_q | weight_load_done;
    all_of       = f_of_q | out_fm_load_done;
    unique case (state_q)
      S_IDLE: begin
        if (conv_start) begin
          state_d    = S_LOAD;
          ld_start_d = 1'b1;
          n_d        = '0;
          m_d        = '0;
          r_d        = '0;
          c_d        = '0;
          cnt_d      = '0;
        end
      end
      S_LOAD: begin
        // Same-cycle arrival of the final done counts toward completion.
        f_in_d = all_in;
        f_wt_d = all_wt;
        f_of_d = all_of;
        if (all_in && all_wt && all_of) begin
          state_d      = S_COMP;
          comp_start_d = 1'b1;
          f_in_d       = 1'b0;
          f_wt_d       = 1'b0;
          f_of_d       = 1'b0;
        end
      end
      S_COMP: begin
        if (compute_done) begin
          if (STORE_GAP == 0) begin
            state_d    = S_STORE;
            st_start_d = 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = GW'(STORE_GAP);
          end
        end
      end
      S_GAP: begin
        // Leaving as the counter steps 1->0 gives STORE_GAP+1 cycles from compute_done.
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) begin
          state_d    = S_STORE;
          st_start_d = 1'b1;
        end
      end
      S_STORE: begin
        if (store_done) begin
          state_d = S_NEXT;
          cnt_d   = cnt_q + IW'(1);
        end
      end
      S_NEXT: begin
        m_d = m_last ? '0 : m_q + IW'(1);
        if (m_last) c_d = c_last ? '0 : c_q + IW'(1);
        if (m_last && c_last) r_d = r_last ? '0 : r_q + IW'(1);
        if (m_last && c_last && r_last) n_d = n_last ? '0 : n_q + IW'(1);
        if (tile_last) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_LOAD;
          ld_start_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ld_start_q   <= 1'b0;
      comp_start_q <= 1'b0;
      st_start_q   <= 1'b0;
      f_in_q       <= 1'b0;
      f_wt_q       <= 1'b0;
      f_of_q       <= 1'b0;
      gap_q        <= '0;
      n_q          <= '0;
      m_q          <= '0;
      r_q          <= '0;
      c_q          <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ld_start_q   <= ld_start_d;
      comp_start_q <= comp_start_d;
      st_start_q   <= st_start_d;
      f_in_q       <= f_in_d;
      f_wt_q       <= f_wt_d;
      f_of_q       <= f_of_d;
      gap_q        <= gap_d;
      n_q          <= n_d;
      m_q          <= m_d;
      r_q          <= r_d;
      c_q          <= c_d;
      cnt_q        <= cnt_d;
    end
  end

  assign conv_done         = (state_q == S_NEXT) && tile_last;
  assign busy              = (state_q != S_IDLE);
  assign in_fm_load_start  = ld_start_q;
  assign weight_load_start = ld_start_q;
  assign out_fm_load_start = ld_start_q;
  assign compute_start     = comp_start_q;
  assign store_start       = st_start_q;
  assign tile_n_idx        = n_q;
  assign tile_m_idx        = m_q;
  assign tile_r_idx        = r_q;
  assign tile_c_idx        = c_q;
  assign tile_cnt          = cnt_q;

endmodule

// File: doc/conv_tile_scheduler.md
Name: conv_tile_scheduler

Overview:
Top-level sequencer for the tiled convolution datapath. It walks every tile of an N x M x R x C layer and, for each tile, runs the same phases in order:
- starts the in_fm, weight and out_fm loads in parallel;
- waits until all three loads are complete;
- launches conv_core computing;
- waits a programmable gap, then launches the out_fm store.

It replaces the single-tile hand wiring (fixed last-load selection, fixed store delay) with a multi-tile FSM. It drives the tile indices that the address generators use.

Parameters:
N, 16, total output channels
M, 16, total input channels
R, 32, total feature rows
C, 16, total feature columns
Tn, 8, output-channel tile size (N divisible by Tn)
Tm, 8, input-channel tile size (M divisible by Tm)
Tr, 16, row tile size (R divisible by Tr)
Tc, 8, column tile size (C divisible by Tc)
IW, 8, width of each tile index and of tile_cnt
STORE_GAP, 0, idle cycles between compute_done and store_start (0 = next cycle)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
conv_start  in  1  single-cycle request to process the whole layer
conv_done  out  1  single-cycle pulse after the last tile's store completes
busy  out  1  high from conv_start acceptance until conv_done, inclusive
in_fm_load_start  out  1  one-cycle pulse, start in_fm tile load
in_fm_load_done  in  1  one-cycle pulse from in_fm loader
weight_load_start  out  1  one-cycle pulse, start weight tile load
weight_load_done  in  1  one-cycle pulse from weight loader
out_fm_load_start  out  1  one-cycle pulse, start out_fm (partial sum) tile load
out_fm_load_done  in  1  one-cycle pulse from out_fm loader
compute_start  out  1  one-cycle pulse to conv_core
compute_done  in  1  one-cycle pulse from conv_core
store_start  out  1  one-cycle pulse, start out_fm tile store
store_done  in  1  one-cycle pulse from store engine
tile_n_idx  out  IW  current output-channel tile index, 0..N/Tn-1
tile_m_idx  out  IW  current input-channel tile index, 0..M/Tm-1
tile_r_idx  out  IW  current row tile index, 0..R/Tr-1
tile_c_idx  out  IW  current column tile index, 0..C/Tc-1
tile_cnt  out  IW  tiles completed so far in this layer

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. All outputs are 0, all tile indices and tile_cnt are 0, sticky flags and the gap counter are cleared. Any operation in flight is abandoned. Done pulses arriving after reset are ignored until a new conv_start.
- States: IDLE, LOAD, COMP, GAP, STORE, NEXT.
- IDLE:
  - conv_start=1 at an edge moves the FSM to LOAD and sets busy; indices are 0.
  - The three *_load_start outputs are high for exactly the one cycle after conv_start is sampled.
- LOAD:
  - Holds three sticky flags, one per load. Each *_load_done sets its flag; dones may arrive in any order or in the same cycle.
  - When all three flags are set, counting the same-cycle arrival, the FSM goes to COMP and compute_start pulses for one cycle. Flags clear.
- COMP:
  - On compute_done: if STORE_GAP=0, go to STORE and pulse store_start the next cycle.
  - Otherwise go to GAP and load the counter with STORE_GAP.
- GAP: decrement the counter each cycle. When it reaches 0, go to STORE and pulse store_start. The compute_done-to-store_start distance is exactly STORE_GAP+1 cycles.
- STORE: on store_done, go to NEXT.
- NEXT (one cycle):
  - tile_cnt increments.
  - Index advance order, innermost first: m, then c, then r, then n. Each index wraps to 0 at its max and carries into the next.
  - If the tile just finished was the last (all indices at max), conv_done pulses this cycle. The FSM then goes to IDLE, busy falls the following cycle, and indices return to 0.
  - Otherwise the FSM goes to LOAD and the three load starts pulse the next cycle.
- Indices are stable from a tile's load_start through its store_done.
- Total tiles = (N/Tn)(M/Tm)(R/Tr)(C/Tc); the default is 16.
- conv_start while busy is ignored.
- Done inputs that do not match the current state are ignored and never set sticky flags: load dones outside LOAD, compute_done outside COMP, store_done outside STORE.
- At most one *_start output is high in any cycle, except the three load starts, which always pulse together.

Test Plan:
1. Defaults, all loaders reply with a done 5 cycles after start, compute 20, store 10 -> exactly 16 compute_start pulses. Index sequence begins (n,r,c,m) = (0,0,0,0), (0,0,0,1), (0,0,1,0). conv_done pulses once, with tile_cnt=16; busy then drops.
2. In one tile, weight_done, in_fm_done and out_fm_done arrive at cycles 3, 7, 7 after load start -> compute_start fires exactly 1 cycle after cycle 7. Repeat with all three in the same cycle; result is identical.
3. STORE_GAP=120 -> store_start occurs 121 cycles after each compute_done. STORE_GAP=0 -> 1 cycle.
4. conv_start pulsed again mid-layer, plus a stray compute_done during LOAD -> no effect. Tile count, index sequence and conv_done timing are unchanged versus scenario 1.
5. rst asserted during COMP of tile 5 -> all outputs 0 immediately. A subsequent conv_start restarts at tile (0,0,0,0) with tile_cnt=0.
6. N=M=Tn=Tm=8, R=Tr=16, C=Tc=8 (single tile) -> one load/compute/store cycle, then conv_done with tile_cnt=1.
